awgn_channel_multi: RTL and testbench
=====================================

AWGN_CHANNEL_MULTI -- requirements
Module: awgn_channel_multi

Interface
REQ-001 Parameters SHALL be:
  DATA_W, 18, sample width (signed two's complement) per channel.
  NUM_CH, 2, number of independent channels (I/Q = 2).
  GAIN_W, 16, noise gain width (unsigned).
  GAIN_FRAC, 8, fractional bits of noise gain.
  RST_SEED, 32'hACE1_2468, LFSR base seed applied at reset.
REQ-002 Ports SHALL be:
  clk  in  1  single clock, all logic rising-edge.
  rst  in  1  synchronous reset, active-high.
  in_valid  in  1  input sample strobe.
  in_data  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
  mode  in  2  00 bypass, 01 add noise, 10 noise only, 11 treated as 01.
  noise_gain  in  GAIN_W  unsigned noise scale, Q(GAIN_W-GAIN_FRAC).GAIN_FRAC.
  seed_load  in  1  reload all LFSRs from seed.
  seed  in  32  base seed for seed_load.
  out_valid  out  1  output sample strobe.
  out_data  out  NUM_CH*DATA_W  same packing as in_data.
  sat_count  out  16  count of output beats with any saturated channel.
REQ-003 One clock domain; reset is synchronous and active-high; there is no backpressure.

Function
REQ-004 Each channel c SHALL own a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), shifting right.
REQ-005 The LFSR seed for channel c SHALL be base seed rotated left by 7*c bits; a resulting value of 0 SHALL be replaced by 32'h0000_0001.
REQ-006 An LFSR SHALL advance exactly one step per cycle in which in_valid=1 and seed_load=0, in every mode including bypass.
REQ-007 With seed_load=1, all LFSRs SHALL load their seeds at the next edge with no advance; a same-cycle in_valid sample SHALL use the pre-load state.
REQ-008 Noise sample n_c SHALL be (s[9:0]-512)+(s[19:10]-512)+(s[29:20]-512) from the current LFSR state s, as 12-bit signed, range -1536..+1533.
REQ-009 Scaled noise SHALL be (n_c * {1'b0,noise_gain}) arithmetically shifted right by GAIN_FRAC (floor), full precision, no intermediate truncation.
REQ-010 Result per channel: mode 00 -> in_data; mode 01/11 -> in_data + scaled noise; mode 10 -> scaled noise; result saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-011 Pipeline SHALL be 3 stages: S1 registers data, n_c, mode, gain; S2 registers products; S3 registers add/saturate results into out_data.
REQ-012 out_valid SHALL equal in_valid delayed exactly 3 cycles; throughput one sample per cycle; bubbles propagate unchanged.
REQ-013 mode and noise_gain SHALL be sampled only in the S1 cycle of each sample; later changes do not affect in-flight samples.
REQ-014 out_data SHALL update only when out_valid=1 and hold its value otherwise.
REQ-015 sat_count SHALL increment by 1 for each out_valid beat in which at least one channel clipped, and SHALL stick at 16'hFFFF.
REQ-016 Mode 00 SHALL never count saturation; mode 10 counts only if the scaled noise exceeds the output range.

Reset
REQ-017 On rst=1 at an edge: all pipeline valids 0, out_valid 0, out_data 0, sat_count 0, LFSRs loaded from RST_SEED per REQ-005; rst overrides seed_load and in_valid.
REQ-018 Samples in flight when rst asserts SHALL be discarded; no out_valid until 3 cycles after the first in_valid following rst release.

Verification
REQ-019 Bypass: mode=00, in_data ch0=12345, ch1=-7 for one cycle -> out_valid exactly 3 cycles later with identical data, sat_count=0; LFSR state advanced one step versus golden model.
REQ-020 Zero gain: mode=01, noise_gain=0, 1000 random back-to-back samples -> out_data equals in_data, out_valid continuous after 3-cycle latency.
REQ-021 Saturation: mode=01, noise_gain=16'hFFFF, in_data=+131071 on both channels for 100 cycles -> every output within [-131072,131071], sat_count equals reference-model count of clipped beats.
REQ-022 Determinism: seed_load with seed=32'h1234_5678, then 256 samples mode=10 gain=16'h0100 -> out_data matches bit-exact golden model (noise = n_c); repeat after identical reseed gives identical sequence; seed=0 gives ch0 seed 1.
REQ-023 Reset mid-stream: rst asserted for one cycle while 3 samples in flight -> no out_valid from those samples, sat_count=0, next post-reset output matches RST_SEED model.
REQ-024 Statistics: mode=10, gain=16'h0100, 65536 samples -> per-channel mean within +/-8, variance within 5% of 3*(1024^2-1)/12, ch0/ch1 correlation below 0.02.

Source files
------------

// File: rtl/awgn_channel_multi.sv
// Multi-channel AWGN injector: one Galois LFSR per channel feeds an Irwin-Hall(3) noise
// sample that is scaled, optionally added to the input, and saturated over a 3-stage pipeline.
module awgn_channel_multi #(
  parameter int unsigned DATA_W    = 18,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned GAIN_W    = 16,
  parameter int unsigned GAIN_FRAC = 8,
  parameter logic [31:0] RST_SEED  = 32'hACE1_2468
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [1:0]               mode,
  input  logic [GAIN_W-1:0]        noise_gain,
  input  logic                     seed_load,
  input  logic [31:0]              seed,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [15:0]              sat_count
);

  localparam int unsigned NoiseW = 12;
  localparam int unsigned ProdW  = NoiseW + GAIN_W + 1;
  localparam int unsigned ScW    = ProdW - GAIN_FRAC;
  localparam int unsigned SumW   = ((ScW > DATA_W) ? ScW : DATA_W) + 1;
  localparam logic [31:0] LfsrMask = 32'h8020_0003;
  localparam logic signed [SumW-1:0] SatMax = SumW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [SumW-1:0] SatMin = ~SatMax;

  typedef enum logic [1:0] {
    ModeBypass = 2'b00,
    ModeAdd    = 2'b01,
    ModeNoise  = 2'b10,
    ModeAddAlt = 2'b11
  } mode_e;

  function automatic logic [31:0] chan_seed(input logic [31:0] base, input int unsigned ch);
    logic [63:0] dbl;
    logic [31:0] rot;
    dbl = {base, base} << ((7 * ch) % 32);
    rot = dbl[63:32];
    return (rot == 32'h0) ? 32'h0000_0001 : rot;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LfsrMask : 32'h0);
  endfunction

  // Sum of three centred 10-bit uniforms; range -1536..+1533 fits 12 bits signed.
  function automatic logic signed [NoiseW-1:0] noise_of(input logic [31:0] s);
    logic signed [NoiseW-1:0] a, b, c;
    a = $signed({2'b00, s[9:0]})   - 12'sd512;
    b = $signed({2'b00, s[19:10]}) - 12'sd512;
    c = $signed({2'b00, s[29:20]}) - 12'sd512;
    return a + b + c;
  endfunction

  logic [NUM_CH-1:0][DATA_W-1:0] in_ch;
  assign in_ch = in_data;

  // LFSR bank
  logic [NUM_CH-1:0][31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (seed_load) begin
        lfsr_d[c] = chan_seed(seed, c);
      end else if (in_valid) begin
        lfsr_d[c] = lfsr_step(lfsr_q[c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        lfsr_q[c] <= chan_seed(RST_SEED, c);
      end
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Stage 1: capture data, raw noise, mode and gain
  logic                          v1_q;
  logic [NUM_CH-1:0][DATA_W-1:0] data1_q;
  logic [NUM_CH-1:0][NoiseW-1:0] noise1_q, noise1_d;
  mode_e                         mode1_q;
  logic [GAIN_W-1:0]             gain1_q;

  always_comb begin
    noise1_d = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      noise1_d[c] = noise_of(lfsr_q[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      data1_q  <= '0;
      noise1_q <= '0;
      mode1_q  <= ModeBypass;
      gain1_q  <= '0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        data1_q  <= in_ch;
        noise1_q <= noise1_d;
        mode1_q  <= mode_e'(mode);
        gain1_q  <= noise_gain;
      end
    end
  end

  // Stage 2: full-precision scaling, floor shift
  logic                          v2_q;
  logic [NUM_CH-1:0][DATA_W-1:0] data2_q;
  logic [NUM_CH-1:0][ScW-1:0]    scaled2_q, scaled2_d;
  mode_e                         mode2_q;

  always_comb begin
    logic signed [ProdW-1:0] n_ext, g_ext, prod;
    scaled2_d = '0;
    n_ext     = '0;
    g_ext     = '0;
    prod      = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      n_ext        = ProdW'($signed(noise1_q[c]));
      g_ext        = ProdW'({1'b0, gain1_q});
      prod         = n_ext * g_ext;
      scaled2_d[c] = ScW'(prod >>> GAIN_FRAC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q      <= 1'b0;
      data2_q   <= '0;
      scaled2_q <= '0;
      mode2_q   <= ModeBypass;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        data2_q   <= data1_q;
        scaled2_q <= scaled2_d;
        mode2_q   <= mode1_q;
      end
    end
  end

  // Stage 3: select, add, saturate
  logic [NUM_CH-1:0][DATA_W-1:0] res;
  logic                          any_clip;
  logic                          v3_q;
  logic [NUM_CH-1:0][DATA_W-1:0] out_q;
  logic [15:0]                   sat_q;

  always_comb begin
    logic signed [SumW-1:0] d_ext, s_ext, sum;
    res      = '0;
    any_clip = 1'b0;
    d_ext    = '0;
    s_ext    = '0;
    sum      = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      d_ext = SumW'($signed(data2_q[c]));
      s_ext = SumW'($signed(scaled2_q[c]));
      case (mode2_q)
        ModeBypass: sum = d_ext;
        ModeNoise:  sum = s_ext;
        default:    sum = d_ext + s_ext;
      endcase
      if (sum > SatMax) begin
        res[c]   = SatMax[DATA_W-1:0];
        any_clip = 1'b1;
      end else if (sum < SatMin) begin
        res[c]   = SatMin[DATA_W-1:0];
        any_clip = 1'b1;
      end else begin
        res[c] = sum[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q  <= 1'b0;
      out_q <= '0;
      sat_q <= '0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) begin
        out_q <= res;
        if (any_clip && (sat_q != 16'hFFFF)) begin
          sat_q <= sat_q + 16'd1;
        end
      end
    end
  end

  assign out_valid = v3_q;
  assign out_data  = out_q;
  assign sat_count = sat_q;

endmodule

// File: tb/tb_awgn_channel_multi.sv
// Directed/table bench for awgn_channel_multi with a cycle-level golden model of the channel.
module tb_awgn_channel_multi;

  localparam int DW = 18;
  localparam bit [31:0] RstSeed = 32'hACE1_2468;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [2*DW-1:0] in_data;
  logic [1:0]      mode;
  logic [15:0]     noise_gain;
  logic            seed_load;
  logic [31:0]     seed;
  logic            out_valid;
  logic [2*DW-1:0] out_data;
  logic [15:0]     sat_count;

  awgn_channel_multi dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .mode       (mode),
    .noise_gain (noise_gain),
    .seed_load  (seed_load),
    .seed       (seed),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [1:0]  md;
    bit [15:0] g;
    int        d0;
    int        d1;
    int        e0;
    int        e1;
  } vec_t;

  vec_t tbl[6];

  int n_chk  = 0;
  int n_fail = 0;

  bit [31:0] m_lfsr[2];
  bit        pv[3];
  int        pd[3][2];
  bit        ps[3];
  int        ptag[3];
  int        exp_d[2];
  bit [15:0] exp_sat;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit [31:0] m_seed(input bit [31:0] b, input int c);
    bit [31:0] r;
    r = b;
    repeat (7 * c) r = {r[30:0], r[31]};
    if (r == 32'h0) r = 32'h1;
    return r;
  endfunction

  function automatic bit [31:0] m_step(input bit [31:0] s);
    bit lsb;
    lsb = s[0];
    s = s >> 1;
    if (lsb) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  function automatic void model_chan(input bit [31:0] s, input bit [1:0] md, input bit [15:0] g,
                                     input int d, output int r, output bit clip);
    int n;
    longint p, sc, sum;
    n = int'(s[9:0]) - 512 + int'(s[19:10]) - 512 + int'(s[29:20]) - 512;
    p = longint'(n) * longint'(g);
    sc = p >>> 8;
    case (md)
      2'b00:   sum = d;
      2'b10:   sum = sc;
      default: sum = d + sc;
    endcase
    clip = 1'b1;
    if (sum > 131071) r = 131071;
    else if (sum < -131072) r = -131072;
    else begin
      r = int'(sum);
      clip = 1'b0;
    end
  endfunction

  function automatic int out_ch(input int c);
    logic [DW-1:0] v;
    v = out_data[c*DW +: DW];
    return int'($signed(v));
  endfunction

  task automatic drive_cycle(input bit r, input bit iv, input bit [1:0] md, input bit [15:0] g,
                             input int d0, input int d1, input bit sl, input bit [31:0] sd,
                             input int tag);
    int res[2];
    bit clip[2];
    bit nv;
    logic [DW-1:0] x0, x1;
    x0 = DW'(d0);
    x1 = DW'(d1);
    rst = r; in_valid = iv; mode = md; noise_gain = g;
    in_data = {x1, x0}; seed_load = sl; seed = sd;
    nv = iv && !r;
    model_chan(m_lfsr[0], md, g, d0, res[0], clip[0]);
    model_chan(m_lfsr[1], md, g, d1, res[1], clip[1]);
    for (int c = 0; c < 2; c++) begin
      if (r) m_lfsr[c] = m_seed(RstSeed, c);
      else if (sl) m_lfsr[c] = m_seed(sd, c);
      else if (iv) m_lfsr[c] = m_step(m_lfsr[c]);
    end
    @(posedge clk);
    #1;
    for (int i = 2; i > 0; i--) begin
      pv[i] = pv[i-1]; pd[i] = pd[i-1]; ps[i] = ps[i-1]; ptag[i] = ptag[i-1];
    end
    pv[0] = nv; pd[0][0] = res[0]; pd[0][1] = res[1];
    ps[0] = nv && (clip[0] || clip[1]); ptag[0] = nv ? tag : -1;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        pv[i] = 1'b0; ps[i] = 1'b0; ptag[i] = -1;
      end
      exp_d[0] = 0; exp_d[1] = 0; exp_sat = 16'h0;
    end
    if (pv[2]) begin
      exp_d = pd[2];
      if (ps[2] && exp_sat != 16'hFFFF) exp_sat++;
    end
    chk("out_valid", longint'(out_valid), longint'(pv[2]));
    chk("out_ch0", out_ch(0), exp_d[0]);
    chk("out_ch1", out_ch(1), exp_d[1]);
    chk("sat_count", longint'(sat_count), longint'(exp_sat));
    if (pv[2] && ptag[2] >= 0) begin
      chk("tbl_ch0", out_ch(0), tbl[ptag[2]].e0);
      chk("tbl_ch1", out_ch(1), tbl[ptag[2]].e1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 1'b0, 2'b00, 16'h0, 0, 0, 1'b0, 32'h0, -1);
  endtask

  task automatic do_reset();
    drive_cycle(1'b1, 1'b0, 2'b00, 16'h0, 0, 0, 1'b0, 32'h0, -1);
  endtask

  initial begin
    tbl[0] = '{2'b00, 16'h0100, 12345, -7, 12345, -7};
    tbl[1] = '{2'b00, 16'hFFFF, 131071, -131072, 131071, -131072};
    tbl[2] = '{2'b01, 16'h0000, -1000, 5000, -1000, 5000};
    tbl[3] = '{2'b11, 16'h0000, 77, -77, 77, -77};
    tbl[4] = '{2'b10, 16'h0000, 999, -999, 0, 0};
    tbl[5] = '{2'b01, 16'h0000, 131071, -131072, 131071, -131072};

    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0; ps[i] = 1'b0; ptag[i] = -1; pd[i][0] = 0; pd[i][1] = 0;
    end

    do_reset();
    do_reset();
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_sat_count", longint'(sat_count), 0);

    // First sample from reset seed: hand-computed noise for ch0 is -641
    drive_cycle(1'b0, 1'b1, 2'b10, 16'h0100, 0, 0, 1'b0, 32'h0, -1);
    idle(3);
    chk("rst_seed_ch0", out_ch(0), -641);

    // Directed table, back-to-back
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 1'b1, tbl[i].md, tbl[i].g, tbl[i].d0, tbl[i].d1, 1'b0, 32'h0, i);
    end
    idle(4);

    // Zero gain, random data, continuous stream
    for (int i = 0; i < 1000; i++) begin
      drive_cycle(1'b0, 1'b1, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01, 16'h0,
                  int'($urandom_range(0, 262143)) - 131072,
                  int'($urandom_range(0, 262143)) - 131072, 1'b0, 32'h0, -1);
    end
    idle(3);

    // Saturation at full gain
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b0, 1'b1, 2'b01, 16'hFFFF, 131071, 131071, 1'b0, 32'h0, -1);
    end
    idle(3);

    // Reseed with a same-cycle sample (must use pre-load state), then noise-only run
    drive_cycle(1'b0, 1'b1, 2'b10, 16'h0100, 0, 0, 1'b1, 32'h1234_5678, -1);
    for (int i = 0; i < 256; i++) begin
      drive_cycle(1'b0, 1'b1, 2'b10, 16'h0100, 0, 0, 1'b0, 32'h0, -1);
    end
    // Same reseed, with bubbles and per-sample mode/gain changes
    drive_cycle(1'b0, 1'b0, 2'b00, 16'h0, 0, 0, 1'b1, 32'h1234_5678, -1);
    for (int i = 0; i < 128; i++) begin
      drive_cycle(1'b0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  16'($urandom_range(0, 65535)), int'($urandom_range(0, 262143)) - 131072,
                  int'($urandom_range(0, 262143)) - 131072, 1'b0, 32'h0, -1);
    end
    idle(3);

    // Zero seed maps to 1 on both channels: noise = -511-512-512
    drive_cycle(1'b0, 1'b0, 2'b00, 16'h0, 0, 0, 1'b1, 32'h0, -1);
    drive_cycle(1'b0, 1'b1, 2'b10, 16'h0100, 0, 0, 1'b0, 32'h0, -1);
    idle(3);
    chk("seed0_ch0", out_ch(0), -1535);
    chk("seed0_ch1", out_ch(1), -1535);

    // Reset with samples in flight
    drive_cycle(1'b0, 1'b1, 2'b01, 16'hFFFF, 131071, -131072, 1'b0, 32'h0, -1);
    drive_cycle(1'b0, 1'b1, 2'b01, 16'hFFFF, 131071, -131072, 1'b0, 32'h0, -1);
    drive_cycle(1'b1, 1'b1, 2'b01, 16'hFFFF, 131071, -131072, 1'b0, 32'h0, -1);
    idle(3);
    chk("midrst_sat", longint'(sat_count), 0);
    chk("midrst_valid", longint'(out_valid), 0);
    drive_cycle(1'b0, 1'b1, 2'b10, 16'h0100, 0, 0, 1'b0, 32'h0, -1);
    idle(3);
    chk("midrst_seed_ch0", out_ch(0), -641);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
